// File: rtl/img_proc_pkg.sv
// Shared definitions for the image-processing output path: select-controller
// FSM encodings, source limits and the pixel value used while blanking.
package img_proc_pkg;

  localparam int N_SRC_MAX = 4;
  localparam int SEL_W     = 2;

  localparam logic [23:0] BLACK_PIXEL = 24'h000000;

  typedef logic [1:0] state_t;

  localparam state_t STABLE  = 2'd0;
  localparam state_t PENDING = 2'd1;
  localparam state_t BLANK   = 2'd2;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-high counter and a
// single-cycle press pulse on the debounced level's rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int DB_W         = 20
) (
  input  logic Clock,
  input  logic Reset,
  input  logic btn,
  output logic press
);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] cnt;
  logic            level;
  logic            level_d;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // The counter saturates once the level is accepted, so holding the
  // button keeps the level high without producing further presses.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      level_d <= level;
      if (!sync2) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
        level <= 1'b1;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/img_mux_sel_ctrl.sv
// Frame-synchronous select controller for the output mux: arbitrates force,
// button and auto-cycle requests and switches only on vsync rising edges.
module img_mux_sel_ctrl #(
  parameter int N_SRC           = 4,
  parameter int SEL_W           = 2,
  parameter int DEBOUNCE_CYC    = 1000000,
  parameter int DB_W            = 20,
  parameter int FRAMES_PER_MODE = 60,
  parameter int FR_W            = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             vsync,
  input  logic             btn_next,
  input  logic             auto_en,
  input  logic             force_valid,
  input  logic [SEL_W-1:0] force_sel,
  output logic [SEL_W-1:0] sel,
  output logic             blank,
  output logic             pending,
  output logic             switch_done
);

  import img_proc_pkg::*;

  state_t           state;
  logic [SEL_W-1:0] target;
  logic [SEL_W-1:0] next_sel;
  logic [FR_W-1:0]  fr_cnt;
  logic             vsync_d;
  logic             vs_edge;
  logic             press;
  logic             auto_req;
  logic             force_legal;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .DB_W         (DB_W)
  ) u_btn (
    .Clock (Clock),
    .Reset (Reset),
    .btn   (btn_next),
    .press (press)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) vsync_d <= 1'b0;
    else        vsync_d <= vsync;
  end

  always_comb begin
    vs_edge     = vsync & ~vsync_d;
    next_sel    = (sel == SEL_W'(N_SRC - 1)) ? '0 : sel + SEL_W'(1);
    force_legal = force_valid && (int'(force_sel) < N_SRC);
    auto_req    = vs_edge && (state == STABLE) && auto_en &&
                  (fr_cnt == FR_W'(FRAMES_PER_MODE - 1));
  end

  // Frames are only counted while the output is stable, so the blanked
  // frame of a switch never counts towards the next auto step.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      fr_cnt <= '0;
    end else if (!auto_en || switch_done) begin
      fr_cnt <= '0;
    end else if (vs_edge && (state == STABLE)) begin
      fr_cnt <= auto_req ? '0 : fr_cnt + FR_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= STABLE;
      target      <= '0;
      sel         <= '0;
      blank       <= 1'b0;
      pending     <= 1'b0;
      switch_done <= 1'b0;
    end else begin
      switch_done <= 1'b0;
      case (state)
        STABLE: begin
          if (force_legal && (force_sel != sel)) begin
            target  <= force_sel;
            pending <= 1'b1;
            state   <= PENDING;
          end else if (press || auto_req) begin
            target  <= next_sel;
            pending <= 1'b1;
            state   <= PENDING;
          end
        end
        PENDING: begin
          // Forcing back to the live source withdraws the switch entirely.
          if (force_legal && (force_sel == sel)) begin
            pending <= 1'b0;
            state   <= STABLE;
          end else if (vs_edge) begin
            sel     <= force_legal ? force_sel : target;
            blank   <= 1'b1;
            pending <= 1'b0;
            state   <= BLANK;
          end else if (force_legal) begin
            target <= force_sel;
          end
        end
        BLANK: begin
          if (vs_edge) begin
            blank       <= 1'b0;
            switch_done <= 1'b1;
            state       <= STABLE;
          end
        end
        default: state <= STABLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_mux_sel_ctrl.sv
// Directed bench for img_mux_sel_ctrl: a cycle-level vector table for the
// force/cancel paths plus hand sequences for debounce, wrap, blank and auto.
module tb_img_mux_sel_ctrl;

  localparam int FRAME_CYC = 100;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       vsync = 1'b0;
  logic       btn_next = 1'b0;
  logic       auto_en = 1'b0;
  logic       force_valid = 1'b0;
  logic [2:0] force_sel = 3'd0;
  logic [2:0] sel;
  logic       blank;
  logic       pending;
  logic       switch_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       vs;
    logic       fv;
    logic [2:0] fs;
    logic [2:0] sel;
    logic       blank;
    logic       pend;
    logic       done;
  } vec_t;

  vec_t vecs [25];

  img_mux_sel_ctrl #(
    .N_SRC           (4),
    .SEL_W           (3),
    .DEBOUNCE_CYC    (8),
    .DB_W            (4),
    .FRAMES_PER_MODE (3),
    .FR_W            (4)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .vsync       (vsync),
    .btn_next    (btn_next),
    .auto_en     (auto_en),
    .force_valid (force_valid),
    .force_sel   (force_sel),
    .sel         (sel),
    .blank       (blank),
    .pending     (pending),
    .switch_done (switch_done)
  );

  always #5 Clock = ~Clock;

  function automatic vec_t mk(logic vs, logic fv, logic [2:0] fs, logic [2:0] s,
                              logic b, logic p, logic d);
    vec_t v;
    v.vs = vs; v.fv = fv; v.fs = fs; v.sel = s; v.blank = b; v.pend = p; v.done = d;
    return v;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(int n);
    vsync = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Raises vsync for one cycle; outputs afterwards reflect the edge.
  task automatic doEdge();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  task automatic frame();
    idle(FRAME_CYC - 1);
    doEdge();
  endtask

  task automatic pressBtn(int n);
    btn_next = 1'b1;
    for (int i = 0; i < n; i++) tick();
    btn_next = 1'b0;
  endtask

  task automatic forcePulse(logic [2:0] v);
    force_valid = 1'b1;
    force_sel   = v;
    tick();
    force_valid = 1'b0;
  endtask

  task automatic applyStimulus(logic vs, logic fv, logic [2:0] fs);
    vsync       = vs;
    force_valid = fv;
    force_sel   = fs;
    tick();
  endtask

  task automatic checkOutput(string name, logic [2:0] s, logic b, logic p, logic d);
    checks++;
    if (sel !== s || blank !== b || pending !== p || switch_done !== d) begin
      errors++;
      $display("[TB] FAIL %s: got sel=%0d blank=%0b pending=%0b done=%0b, expected sel=%0d blank=%0b pending=%0b done=%0b",
               name, sel, blank, pending, switch_done, s, b, p, d);
    end
  endtask

  task automatic resetDut();
    Reset = 1'b0;
    vsync = 1'b0; btn_next = 1'b0; auto_en = 1'b0; force_valid = 1'b0; force_sel = 3'd0;
    idle(3);
    Reset = 1'b1;
    tick();
  endtask

  logic [2:0] autoSel   [9] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2};
  logic       autoBlank [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       autoPend  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       autoDone  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    // Rows start from sel=0, STABLE, vsync low; each row is one clock.
    vecs[0]  = mk(0, 1, 3'd5, 3'd0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 3'd0, 3'd0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 3'd2, 3'd0, 0, 1, 0);
    vecs[3]  = mk(0, 0, 3'd0, 3'd0, 0, 1, 0);
    vecs[4]  = mk(1, 0, 3'd0, 3'd2, 1, 0, 0);
    vecs[5]  = mk(1, 0, 3'd0, 3'd2, 1, 0, 0);
    vecs[6]  = mk(0, 1, 3'd3, 3'd2, 1, 0, 0);
    vecs[7]  = mk(1, 0, 3'd0, 3'd2, 0, 0, 1);
    vecs[8]  = mk(0, 0, 3'd0, 3'd2, 0, 0, 0);
    vecs[9]  = mk(0, 1, 3'd1, 3'd2, 0, 1, 0);
    vecs[10] = mk(0, 1, 3'd3, 3'd2, 0, 1, 0);
    vecs[11] = mk(1, 0, 3'd0, 3'd3, 1, 0, 0);
    vecs[12] = mk(0, 0, 3'd0, 3'd3, 1, 0, 0);
    vecs[13] = mk(1, 0, 3'd0, 3'd3, 0, 0, 1);
    vecs[14] = mk(0, 1, 3'd0, 3'd3, 0, 1, 0);
    vecs[15] = mk(0, 1, 3'd3, 3'd3, 0, 0, 0);
    vecs[16] = mk(1, 0, 3'd0, 3'd3, 0, 0, 0);
    vecs[17] = mk(0, 0, 3'd0, 3'd3, 0, 0, 0);
    vecs[18] = mk(1, 1, 3'd1, 3'd3, 0, 1, 0);
    vecs[19] = mk(1, 0, 3'd0, 3'd3, 0, 1, 0);
    vecs[20] = mk(0, 0, 3'd0, 3'd3, 0, 1, 0);
    vecs[21] = mk(1, 0, 3'd0, 3'd1, 1, 0, 0);
    vecs[22] = mk(0, 0, 3'd0, 3'd1, 1, 0, 0);
    vecs[23] = mk(1, 0, 3'd0, 3'd1, 0, 0, 1);
    vecs[24] = mk(0, 0, 3'd0, 3'd1, 0, 0, 0);

    // Reset and quiet frames
    resetDut();
    checkOutput("reset", 3'd0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      frame();
      checkOutput("quiet_frame", 3'd0, 0, 0, 0);
    end
    idle(10);

    // Debounce: a short glitch is ignored, a long hold gives one press
    pressBtn(5);
    idle(10);
    checkOutput("glitch_ignored", 3'd0, 0, 0, 0);
    btn_next = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    checkOutput("press_pending", 3'd0, 0, 1, 0);
    doEdge();
    checkOutput("press_switch", 3'd1, 1, 0, 0);
    idle(20);
    doEdge();
    checkOutput("press_done", 3'd1, 0, 0, 1);
    idle(10);
    checkOutput("hold_no_repeat", 3'd1, 0, 0, 0);
    btn_next = 1'b0;
    idle(15);
    checkOutput("release_no_press", 3'd1, 0, 0, 0);

    // Wrap from the last source, then a press during BLANK is dropped
    forcePulse(3'd3);
    checkOutput("force3_pending", 3'd1, 0, 1, 0);
    doEdge();
    idle(20);
    doEdge();
    checkOutput("force3_done", 3'd3, 0, 0, 1);
    pressBtn(15);
    checkOutput("wrap_pending", 3'd3, 0, 1, 0);
    idle(5);
    doEdge();
    checkOutput("wrap_to_0", 3'd0, 1, 0, 0);
    pressBtn(15);
    idle(5);
    checkOutput("blank_press_drop", 3'd0, 1, 0, 0);
    doEdge();
    checkOutput("blank_end", 3'd0, 0, 0, 1);
    idle(5);
    checkOutput("no_second_pend", 3'd0, 0, 0, 0);
    doEdge();
    checkOutput("no_second_switch", 3'd0, 0, 0, 0);
    idle(5);

    // Cycle-level vector table
    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].vs, vecs[i].fv, vecs[i].fs);
      checkOutput($sformatf("vec%0d", i), vecs[i].sel, vecs[i].blank, vecs[i].pend, vecs[i].done);
    end
    force_valid = 1'b0;
    vsync = 1'b0;

    // Asynchronous reset while blanking
    forcePulse(3'd2);
    doEdge();
    checkOutput("pre_reset_blank", 3'd2, 1, 0, 0);
    idle(10);
    Reset = 1'b0;
    #1;
    checkOutput("async_reset", 3'd0, 0, 0, 0);
    tick();
    Reset = 1'b1;
    idle(2);
    checkOutput("after_reset", 3'd0, 0, 0, 0);

    // Auto cycling every three stable frames
    resetDut();
    auto_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      frame();
      checkOutput($sformatf("auto_e%0d", k + 1), autoSel[k], autoBlank[k], autoPend[k], autoDone[k]);
    end
    frame();
    checkOutput("auto_e10", 3'd2, 0, 0, 1);
    frame();
    frame();
    idle(20);
    auto_en = 1'b0;
    tick();
    auto_en = 1'b1;
    frame();
    frame();
    checkOutput("auto_cleared_e14", 3'd2, 0, 0, 0);
    frame();
    checkOutput("auto_restart_e15", 3'd2, 0, 1, 0);
    auto_en = 1'b0;
    frame();
    checkOutput("auto_e16", 3'd3, 1, 0, 0);
    frame();
    checkOutput("auto_e17", 3'd3, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      frame();
      checkOutput("auto_off", 3'd3, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
